// File: rtl/rx_dwns_pkg.sv
// rtl/rx_dwns_pkg.sv - shared types, default sizes and helpers for the energy-phase downsampler
package rx_dwns_pkg;

   function automatic int nb_phase(input int os);
      return (os < 2) ? 1 : $clog2(os);
   endfunction

   localparam int NBT_IN_DEF   = 8;
   localparam int NBF_IN_DEF   = 7;
   localparam int OVERSAMP_DEF = 4;
   localparam int LOG2_WIN_DEF = 10;

   localparam int NB_PHASE  = nb_phase(OVERSAMP_DEF);
   localparam int NB_ENERGY = 2 * NBT_IN_DEF;
   localparam int NB_ACC    = NB_ENERGY + LOG2_WIN_DEF;

   typedef enum logic {
      ACQ  = 1'b0,
      LOCK = 1'b1
   } dwns_state_e;

endpackage

// File: rtl/rx_energy_phase_dwns_argmax.sv
// rtl/rx_energy_phase_dwns_argmax.sv - combinational argmax over phase accumulators
// Ties resolve to the lowest index.
module rx_dwns_argmax
   import rx_dwns_pkg::*;
#(
   parameter int N      = OVERSAMP_DEF,
   parameter int W      = NB_ACC,
   parameter int NB_IDX = NB_PHASE
) (
   input  logic [W-1:0]      vals_i [N],
   output logic [NB_IDX-1:0] idx_o,
   output logic [W-1:0]      max_o
);

   logic [NB_IDX-1:0] best_idx;
   logic [W-1:0]      best_val;

   always_comb begin
      best_idx = '0;
      best_val = vals_i[0];
      for (int k = 1; k < N; k++) begin
         if (vals_i[k] > best_val) begin
            best_val = vals_i[k];
            best_idx = NB_IDX'(k);
         end
      end
   end

   assign idx_o = best_idx;
   assign max_o = best_val;

endmodule

// File: rtl/rx_energy_phase_dwns.sv
// rtl/rx_energy_phase_dwns.sv - max-energy sampling phase estimator and decimator by OVERSAMP
// Define RX_DWNS_PHASE_TRACK_EN to keep re-estimating the phase while locked.
module rx_energy_phase_dwns
   import rx_dwns_pkg::*;
#(
   parameter int NBT_IN   = NBT_IN_DEF,
   parameter int NBF_IN   = NBF_IN_DEF,
   parameter int OVERSAMP = OVERSAMP_DEF,
   parameter int LOG2_WIN = LOG2_WIN_DEF
) (
   input  logic                        clk,
   input  logic                        i_reset,
   input  logic                        i_enable,
   input  logic [NBT_IN-1:0]           i_symI,
   input  logic [NBT_IN-1:0]           i_symQ,
   input  logic                        i_force_phase,
   input  logic [nb_phase(OVERSAMP)-1:0] i_phase_cfg,
   input  logic                        i_rearm,
   output logic [NBT_IN-1:0]           o_symI,
   output logic [NBT_IN-1:0]           o_symQ,
   output logic                        o_valid,
   output logic [nb_phase(OVERSAMP)-1:0] o_phase,
   output logic                        o_locked
);

   localparam int NB_PH = nb_phase(OVERSAMP);
   localparam int NB_E  = 2 * NBT_IN;
   localparam int NB_A  = NB_E + LOG2_WIN;
   localparam logic [NB_PH-1:0] LAST_PH = NB_PH'(OVERSAMP - 1);
`ifdef RX_DWNS_PHASE_TRACK_EN
   localparam bit TRACK = 1'b1;
`else
   localparam bit TRACK = 1'b0;
`endif

   if (OVERSAMP < 2 || NBF_IN >= NBT_IN) begin : g_bad_cfg
      $error("rx_energy_phase_dwns: unsupported parameter set");
   end

   dwns_state_e       state_q, state_d;
   logic [NB_PH-1:0]  cnt_q, cnt_d, phase_q, phase_d, pend_q, pend_d;
   logic [LOG2_WIN-1:0] sym_q, sym_d;
   logic [NB_A-1:0]   acc_q [OVERSAMP];
   logic [NB_A-1:0]   acc_d [OVERSAMP];
   logic [NB_A-1:0]   acc_sum [OVERSAMP];
   logic [NBT_IN-1:0] symI_q, symI_d, symQ_q, symQ_d;
   logic              valid_q, valid_d;

   logic signed [NB_E-1:0] ext_i, ext_q, sq_i, sq_q;
   logic [NB_E-1:0]   energy;
   logic              wrap, win_end, accumulate, take_best;
   logic [NB_PH-1:0]  best_idx;
   logic [NB_A-1:0]   best_val;

   assign ext_i  = NB_E'($signed(i_symI));
   assign ext_q  = NB_E'($signed(i_symQ));
   assign sq_i   = ext_i * ext_i;
   assign sq_q   = ext_q * ext_q;
   assign energy = $unsigned(sq_i) + $unsigned(sq_q);

   assign wrap       = i_enable && (cnt_q == LAST_PH);
   assign win_end    = wrap && (&sym_q);
   assign accumulate = (state_q == ACQ) || TRACK;

   // The sample being taken this cycle counts toward the window decision.
   always_comb begin
      for (int p = 0; p < OVERSAMP; p++) begin
         acc_sum[p] = acc_q[p];
         if (i_enable && cnt_q == NB_PH'(p)) acc_sum[p] = acc_q[p] + NB_A'(energy);
      end
   end

   rx_dwns_argmax #(
      .N      (OVERSAMP),
      .W      (NB_A),
      .NB_IDX (NB_PH)
   ) u_argmax (
      .vals_i (acc_sum),
      .idx_o  (best_idx),
      .max_o  (best_val)
   );

   assign take_best = (state_q == ACQ) || (best_val > acc_sum[phase_q]);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      phase_d = phase_q;
      pend_d  = pend_q;
      sym_d   = sym_q;
      acc_d   = acc_q;
      symI_d  = symI_q;
      symQ_d  = symQ_q;
      valid_d = 1'b0;

      if (i_enable) begin
         cnt_d = (cnt_q == LAST_PH) ? '0 : cnt_q + 1'b1;
         if (cnt_q == phase_q) begin
            valid_d = 1'b1;
            symI_d  = i_symI;
            symQ_d  = i_symQ;
         end
         // Phase changes only at a symbol boundary so no symbol is dropped or doubled.
         if (wrap) phase_d = pend_q;
      end

      if (i_force_phase) begin
         pend_d  = (i_phase_cfg > LAST_PH) ? LAST_PH : i_phase_cfg;
         state_d = ACQ;
         sym_d   = '0;
         foreach (acc_d[p]) acc_d[p] = '0;
      end else if (i_rearm) begin
         state_d = ACQ;
         sym_d   = '0;
         foreach (acc_d[p]) acc_d[p] = '0;
      end else if (i_enable && accumulate) begin
         acc_d = acc_sum;
         if (win_end) begin
            if (take_best) pend_d = best_idx;
            state_d = LOCK;
            sym_d   = '0;
            foreach (acc_d[p]) acc_d[p] = '0;
         end else if (wrap) begin
            sym_d = sym_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (i_reset) begin
         state_q <= ACQ;
         cnt_q   <= '0;
         phase_q <= '0;
         pend_q  <= '0;
         sym_q   <= '0;
         for (int p = 0; p < OVERSAMP; p++) acc_q[p] <= '0;
         symI_q  <= '0;
         symQ_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         phase_q <= phase_d;
         pend_q  <= pend_d;
         sym_q   <= sym_d;
         for (int p = 0; p < OVERSAMP; p++) acc_q[p] <= acc_d[p];
         symI_q  <= symI_d;
         symQ_q  <= symQ_d;
         valid_q <= valid_d;
      end
   end

   assign o_symI   = symI_q;
   assign o_symQ   = symQ_q;
   assign o_valid  = valid_q;
   assign o_phase  = phase_q;
   assign o_locked = (state_q == LOCK);

endmodule

// File: tb/tb_rx_energy_phase_dwns.sv
// tb/tb_rx_energy_phase_dwns.sv - bench for rx_energy_phase_dwns (honours RX_DWNS_PHASE_TRACK_EN)
module tb_rx_energy_phase_dwns;

   localparam int OS  = 4;
   localparam int LW  = 4;
   localparam int WIN = 1 << LW;
`ifdef RX_DWNS_PHASE_TRACK_EN
   localparam bit TRACK = 1'b1;
`else
   localparam bit TRACK = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              i_reset = 1'b1, i_enable = 1'b0, i_force_phase = 1'b0, i_rearm = 1'b0;
   logic signed [7:0] i_symI = '0, i_symQ = '0;
   logic [1:0]        i_phase_cfg = '0;
   logic [7:0]        o_symI, o_symQ;
   logic              o_valid, o_locked;
   logic [1:0]        o_phase;

   rx_energy_phase_dwns #(.NBT_IN(8), .NBF_IN(7), .OVERSAMP(OS), .LOG2_WIN(LW)) dut (
      .clk(clk), .i_reset(i_reset), .i_enable(i_enable), .i_symI(i_symI), .i_symQ(i_symQ),
      .i_force_phase(i_force_phase), .i_phase_cfg(i_phase_cfg), .i_rearm(i_rearm),
      .o_symI(o_symI), .o_symQ(o_symQ), .o_valid(o_valid), .o_phase(o_phase), .o_locked(o_locked)
   );

   int n_checks = 0, n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model: keeps the raw window of (phase, energy) samples and decides by summing them.
   typedef struct { int ph; int e; } samp_t;
   samp_t      win_q[$];
   bit         model_ok = 1'b0, m_locked, m_valid;
   int         m_n, m_phase, m_pend;
   logic [7:0] m_symI, m_symQ;
   int         r_ph, r_e, r_wraps, r_best, r_old_phase, r_old_pend;
   int         r_sums [OS];

   initial forever begin
      @(posedge clk);
      if (i_reset) begin
         m_n = 0; m_phase = 0; m_pend = 0; m_locked = 0; m_valid = 0;
         m_symI = '0; m_symQ = '0; win_q.delete(); model_ok = 1'b1;
      end else if (model_ok) begin
         r_ph = m_n % OS;
         r_e  = int'(i_symI) * int'(i_symI) + int'(i_symQ) * int'(i_symQ);
         r_old_phase = m_phase;
         r_old_pend  = m_pend;
         m_valid = i_enable && (r_ph == r_old_phase);
         if (m_valid) begin m_symI = i_symI; m_symQ = i_symQ; end
         if (i_enable && r_ph == OS - 1) m_phase = r_old_pend;
         if (i_force_phase) begin
            m_pend = (int'(i_phase_cfg) > OS - 1) ? OS - 1 : int'(i_phase_cfg);
            m_locked = 0; win_q.delete();
         end else if (i_rearm) begin
            m_locked = 0; win_q.delete();
         end else if (i_enable && (!m_locked || TRACK)) begin
            win_q.push_back('{r_ph, r_e});
            r_wraps = 0;
            foreach (win_q[k]) if (win_q[k].ph == OS - 1) r_wraps++;
            if (r_ph == OS - 1 && r_wraps == WIN) begin
               foreach (r_sums[p]) r_sums[p] = 0;
               foreach (win_q[k]) r_sums[win_q[k].ph] += win_q[k].e;
               r_best = 0;
               for (int p = 1; p < OS; p++) if (r_sums[p] > r_sums[r_best]) r_best = p;
               if (!m_locked || r_sums[r_best] > r_sums[r_old_phase]) m_pend = r_best;
               m_locked = 1; win_q.delete();
            end
         end
         if (i_enable) m_n++;
      end
   end

   logic [31:0] m_phase_v;
   initial forever begin
      @(negedge clk);
      m_phase_v = m_phase;
      if (model_ok)
         check("model", {o_valid, o_locked, o_phase, o_symI, o_symQ},
                        {m_valid, m_locked, m_phase_v[1:0], m_symI, m_symQ});
   end

   int                tb_n = 0, fv_cnt, gap_bad = 0;
   logic signed [7:0] amp [OS];

   task automatic cyc(input bit en, input logic signed [7:0] si, input logic signed [7:0] sq,
                      input bit frc, input logic [1:0] cfg, input bit rrm, input bit rst);
      i_enable = en; i_symI = si; i_symQ = sq; i_force_phase = frc;
      i_phase_cfg = cfg; i_rearm = rrm; i_reset = rst;
      @(posedge clk);
      #1;
      if (rst) tb_n = 0;
      else if (en) tb_n++;
   endtask

   task automatic do_reset();
      cyc(0, 0, 0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 0, 0, 1);
   endtask

   task automatic set_amp(input logic signed [7:0] a0, a1, a2, a3);
      amp[0] = a0; amp[1] = a1; amp[2] = a2; amp[3] = a3;
   endtask

   task automatic feed(input int ns, input bit gaps, input bit frc, input logic [1:0] cfg,
                       input bit rearm_last);
      fv_cnt = 0;
      for (int k = 0; k < ns; k++) begin
         cyc(1, amp[tb_n % OS], amp[tb_n % OS], frc, cfg, rearm_last && (k == ns - 1), 0);
         fv_cnt += int'(o_valid);
         if (gaps) begin
            cyc(0, 8'sh7f, 8'sh7f, frc, cfg, 0, 0);
            if (o_valid) gap_bad++;
         end
      end
   endtask

   typedef struct {
      bit en; logic signed [7:0] si; logic signed [7:0] sq; bit frc; logic [1:0] cfg;
      bit ev; logic [7:0] ei; logic [7:0] eq; logic [1:0] eph; bit elk;
   } vec_t;
   vec_t tv [14];

   int vsum, dom, frc_left;
   bit r_en, r_frc, r_rrm;
   logic signed [7:0] r_si, r_sq;

   initial begin
      tv[0]  = '{1, 8'sd11, -8'sd3, 0, 2'd0, 1, 8'h0B, 8'hFD, 2'd0, 0};
      tv[1]  = '{1, 8'sd22,  8'sd5, 0, 2'd0, 0, 8'h0B, 8'hFD, 2'd0, 0};
      tv[2]  = '{0, 8'sd33,  8'sd6, 0, 2'd0, 0, 8'h0B, 8'hFD, 2'd0, 0};
      tv[3]  = '{1, 8'sd44,  8'sd7, 0, 2'd0, 0, 8'h0B, 8'hFD, 2'd0, 0};
      tv[4]  = '{1, 8'sd55,  8'sd8, 0, 2'd0, 0, 8'h0B, 8'hFD, 2'd0, 0};
      tv[5]  = '{1, 8'sd66, -8'sd9, 0, 2'd0, 1, 8'h42, 8'hF7, 2'd0, 0};
      tv[6]  = '{0, 8'sd77,  8'sd9, 0, 2'd0, 0, 8'h42, 8'hF7, 2'd0, 0};
      tv[7]  = '{1, 8'sd1,   8'sd1, 1, 2'd3, 0, 8'h42, 8'hF7, 2'd0, 0};
      tv[8]  = '{1, 8'sd2,   8'sd2, 0, 2'd0, 0, 8'h42, 8'hF7, 2'd0, 0};
      tv[9]  = '{1, 8'sd3,   8'sd3, 0, 2'd0, 0, 8'h42, 8'hF7, 2'd3, 0};
      tv[10] = '{1, 8'sd4,   8'sd4, 0, 2'd0, 0, 8'h42, 8'hF7, 2'd3, 0};
      tv[11] = '{1, 8'sd5,   8'sd5, 0, 2'd0, 0, 8'h42, 8'hF7, 2'd3, 0};
      tv[12] = '{1, 8'sd6,   8'sd6, 0, 2'd0, 0, 8'h42, 8'hF7, 2'd3, 0};
      tv[13] = '{1, 8'sd7,  -8'sd7, 0, 2'd0, 1, 8'h07, 8'hF9, 2'd3, 0};

      do_reset();
      check("rst_valid", o_valid, 0);
      check("rst_symI", o_symI, 0);
      check("rst_symQ", o_symQ, 0);
      check("rst_phase", o_phase, 0);
      check("rst_locked", o_locked, 0);

      foreach (tv[i]) begin
         cyc(tv[i].en, tv[i].si, tv[i].sq, tv[i].frc, tv[i].cfg, 0, 0);
         check($sformatf("vec%0d_valid", i), o_valid, tv[i].ev);
         check($sformatf("vec%0d_symI", i), o_symI, tv[i].ei);
         check($sformatf("vec%0d_symQ", i), o_symQ, tv[i].eq);
         check($sformatf("vec%0d_phase", i), o_phase, tv[i].eph);
         check($sformatf("vec%0d_locked", i), o_locked, tv[i].elk);
      end

      // Dominant phase 2, then move energy to phase 0
      do_reset();
      set_amp(0, 0, 8'sh40, 0);
      feed(63, 0, 0, 0, 0);
      check("dom_unlocked_63", o_locked, 0);
      feed(1, 0, 0, 0, 0);
      check("dom_locked_64", o_locked, 1);
      check("dom_phase_before_wrap", o_phase, 0);
      feed(4, 0, 0, 0, 0);
      check("dom_phase", o_phase, 2);
      feed(16, 0, 0, 0, 0);
      check("dom_valid_count", fv_cnt, 4);
      check("dom_symI", o_symI, 8'h40);
      set_amp(8'sh40, 0, 0, 0);
      feed(72, 0, 0, 0, 0);
      check("track_phase", o_phase, TRACK ? 0 : 2);
      check("track_locked", o_locked, 1);

      // Equal energy at phases 1 and 3
      do_reset();
      set_amp(0, 8'sh20, 0, 8'sh20);
      feed(68, 0, 0, 0, 0);
      check("tie_phase", o_phase, 1);
      check("tie_locked", o_locked, 1);

      // Enable gaps
      do_reset();
      set_amp(0, 0, 8'sh40, 0);
      gap_bad = 0;
      feed(63, 1, 0, 0, 0);
      check("gap_unlocked", o_locked, 0);
      feed(1, 1, 0, 0, 0);
      check("gap_locked", o_locked, 1);
      feed(4, 1, 0, 0, 0);
      check("gap_phase", o_phase, 2);
      feed(16, 1, 0, 0, 0);
      check("gap_valid_count", fv_cnt, 4);
      check("gap_symI", o_symI, 8'h40);
      check("gap_no_valid_disabled", gap_bad, 0);

      // Forced phase 3 while locked on 2
      set_amp(8'sh10, 8'sh11, 8'sh12, 8'sh13);
      feed(1, 0, 1, 2'd3, 0);
      vsum = fv_cnt;
      check("force_unlocked", o_locked, 0);
      feed(2, 0, 1, 2'd3, 0);
      vsum += fv_cnt;
      check("force_phase_hold", o_phase, 2);
      check("force_old_sym", o_symI, 8'h12);
      feed(1, 0, 1, 2'd3, 0);
      vsum += fv_cnt;
      check("force_phase_new", o_phase, 3);
      check("force_switch_valids", vsum, 1);
      feed(4, 0, 1, 2'd3, 0);
      check("force_next_valids", fv_cnt, 1);
      check("force_new_sym", o_symI, 8'h13);

      // Rearm on window end, then reset mid-window
      set_amp(0, 8'sh40, 0, 0);
      feed(64, 0, 0, 0, 1);
      check("rearm_unlocked", o_locked, 0);
      feed(4, 0, 0, 0, 0);
      check("rearm_phase_kept", o_phase, 3);
      feed(20, 0, 0, 0, 0);
      do_reset();
      check("mid_rst_valid", o_valid, 0);
      check("mid_rst_symI", o_symI, 0);
      check("mid_rst_symQ", o_symQ, 0);
      check("mid_rst_phase", o_phase, 0);
      check("mid_rst_locked", o_locked, 0);
      feed(63, 0, 0, 0, 0);
      check("reacq_unlocked", o_locked, 0);
      feed(1, 0, 0, 0, 0);
      check("reacq_locked", o_locked, 1);
      feed(4, 0, 0, 0, 0);
      check("reacq_phase", o_phase, 1);

      // Randomised traffic against the reference model
      frc_left = 0;
      dom = 0;
      for (int c = 0; c < 2500; c++) begin
         if (c % 200 == 0) dom = $urandom_range(0, OS - 1);
         r_en = ($urandom_range(0, 9) < 8);
         if (tb_n % OS == dom) r_si = 8'($urandom_range(8'h30, 8'h7f));
         else r_si = 8'($urandom_range(0, 8'h0f));
         r_sq = 8'($urandom_range(0, 8'h7f));
         if ($urandom_range(0, 1) == 1) r_si = -r_si;
         if ($urandom_range(0, 1) == 1) r_sq = -r_sq;
         if (frc_left > 0) begin
            r_frc = 1; frc_left--;
         end else begin
            r_frc = 0;
            if ($urandom_range(0, 299) == 0) frc_left = $urandom_range(1, 6);
         end
         r_rrm = ($urandom_range(0, 249) == 0);
         cyc(r_en, r_si, r_sq, r_frc, 2'($urandom_range(0, 3)), r_rrm, ($urandom_range(0, 599) == 0));
      end
      cyc(0, 0, 0, 0, 0, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
